seven_seg_scanner: RTL

Time-multiplexed display controller that shares one `nibble_to_seven_seg` decoder across `NUM_DIGITS` common-anode digits. It holds a tear-free shadowed display value and scans digits in a fixed order, one at a time. Each digit is shown for a programmable dwell, followed by an all-off blanking gap that suppresses ghosting. It sits between the user logic that produces hex values and the board's digit-enable and segment pins; the shared decoder's `nibblein` is driven from `nibble_out`.

---
 rtl/seven_seg_scanner.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode display scanner with shadowed, tear-free value updates.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading-zero digits (digit 0 always lit).
module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL        = 1000,
  parameter int BLANK_CYCLES = 50
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [3:0]              nibble_out,
  output logic [NUM_DIGITS-1:0]   digit_n,
  output logic                    dp_n,
  output logic                    pending,
  output logic                    frame_start
);

  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int CMAX = (DWELL > BLANK_CYCLES) ? DWELL : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DW_LAST  = CW'(DWELL - 1);
  localparam logic [CW-1:0] BL_LAST  = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  typedef enum logic {SHOW, BLANK} state_t;

  state_t                       state_q, state_d;
  logic                         run_q, run_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0][3:0]   act_q, act_d, shd_q, shd_d;
  logic [NUM_DIGITS-1:0]        actdp_q, actdp_d, shddp_q, shddp_d;
  logic                         pend_d;
  logic                         adv, boundary;
  logic [NUM_DIGITS-1:0]        sup;
  logic [3:0]                   nib_d;
  logic [NUM_DIGITS-1:0]        dig_d;
  logic                         dp_d, fs_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SHOW;
      run_q       <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      act_q       <= '0;
      shd_q       <= '0;
      actdp_q     <= '0;
      shddp_q     <= '0;
      pending     <= 1'b0;
      nibble_out  <= 4'h0;
      digit_n     <= '1;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      act_q       <= act_d;
      shd_q       <= shd_d;
      actdp_q     <= actdp_d;
      shddp_q     <= shddp_d;
      pending     <= pend_d;
      nibble_out  <= nib_d;
      digit_n     <= dig_d;
      dp_n        <= dp_d;
      frame_start <= fs_d;
    end
  end

  // run_q=0 is the post-reset idle: the first clock starts slot 0 and counts as a frame boundary.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    run_d   = 1'b1;
    adv     = 1'b0;
    if (run_q) begin
      if (state_q == SHOW) begin
        if (cnt_q == DW_LAST) begin
          cnt_d = '0;
          if (BLANK_CYCLES == 0) adv = 1'b1;
          else                   state_d = BLANK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        if (cnt_q == BL_LAST) begin
          cnt_d   = '0;
          state_d = SHOW;
          adv     = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
    boundary = !run_q || (adv && (idx_q == IDX_LAST));
    if (adv) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

    act_d   = act_q;
    actdp_d = actdp_q;
    shd_d   = shd_q;
    shddp_d = shddp_q;
    pend_d  = pending;
    if (boundary && load) begin
      act_d   = value_in;
      actdp_d = dp_in;
      pend_d  = 1'b0;
    end else begin
      if (boundary && pending) begin
        act_d   = shd_q;
        actdp_d = shddp_q;
        pend_d  = 1'b0;
      end
      if (load) begin
        shd_d   = value_in;
        shddp_d = dp_in;
        pend_d  = 1'b1;
      end
    end
  end

  // Outputs are computed from next state so they line up with the registered slot.
  always_comb begin
    sup = '0;
`ifdef LEADING_ZERO_BLANK_EN
    sup[NUM_DIGITS-1] = (act_d[NUM_DIGITS-1] == 4'h0);
    for (int i = NUM_DIGITS - 2; i > 0; i--)
      sup[i] = sup[i+1] && (act_d[i] == 4'h0);
`endif
    nib_d = nibble_out;
    dig_d = '1;
    dp_d  = 1'b1;
    fs_d  = boundary;
    if (state_d == SHOW) begin
      nib_d = act_d[idx_d];
      if (!sup[idx_d]) begin
        dig_d[idx_d] = 1'b0;
        dp_d         = ~actdp_d[idx_d];
      end
    end
  end

endmodule
